score_bcd_conv: RTL and testbench
=================================

Name: score_bcd_conv

Overview:
- Sequential binary-to-BCD converter for the score path.
- Takes the binary score from game logic and produces one 4-bit digit code per seven-segment display; each digit feeds the existing per-digit segment decoder.
- Iterative shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake. The game FSM triggers it only when the score changes.

Parameters:
- BIN_W, 10, width of binary input; max representable input 2^BIN_W-1.
- DIGITS, 3, number of BCD digits produced; max displayable value 10^DIGITS-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; samples bin_in.
- bin_in  input  BIN_W  binary score, unsigned.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when digits are valid/updated.
- ovf  output  1  high when the last converted input exceeded 10^DIGITS-1; updated with done.
- bcd_out  output  4*DIGITS  digit codes; [3:0] ones, [7:4] tens, upward.

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, ovf=0, bcd_out=0, internal shift registers=0. Release is synchronous to clk.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch bin_in into the shift register, clear the BCD accumulator and bit counter, go to SHIFT, busy=1 next cycle.
- SHIFT: runs exactly BIN_W cycles. Each cycle, every BCD nibble >=5 gets +3, then the {BCD, bin} concatenation shifts left by 1. After the BIN_W-th shift, go to DONE.
- DONE (one cycle):
  - busy=0, done=1, bcd_out and ovf registered from the accumulator.
  - Next state is IDLE, or SHIFT if start=1 in this cycle (back-to-back accepted).
- Latency: start sampled on edge k -> done=1 and new bcd_out visible after edge k+BIN_W+1. For BIN_W=10, that is 11 cycles.
- start while busy=1 (SHIFT) is ignored; it is neither queued nor restarted.
- bcd_out holds the previous result throughout a conversion. Only the DONE transition changes it; no intermediate values appear.
- Overflow: if the latched input > 10^DIGITS-1, all digits output 4'h9 and ovf=1. Otherwise ovf=0. Compare against the latched copy, not live bin_in.
- Accumulator width is 4*DIGITS. The +3 adjust applies to all DIGITS nibbles every shift cycle.
- Reset mid-conversion aborts immediately; outputs return to reset values and no done is emitted.
- bin_in may change freely after the start cycle.

Optional Feature:
- Macro: SCORE_BCD_LZB_EN.
- Defined (leading-zero blanking):
  - Leading zero digits above the ones digit output blank code 4'hF, which the segment decoder renders dark.
  - The ones digit is never blanked (0 shows as "0").
  - Applied at the DONE register update, so there is no added latency.
  - Saturated output (all 9s) is unaffected.
- Undefined: all digits are output as plain BCD, zeros included.

Decomposition:
- Shared package score_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - BLANK_CODE = 4'hF
  - DIGIT_W = 4
- One natural sub-module: bcd_add3, a combinational nibble cell (in >=5 ? in+3 : in), instantiated DIGITS times via generate.
- Top holds the FSM, bit counter ($clog2(BIN_W+1) bits), shift registers, saturation compare, and the optional blanking logic.

Test Plan (BIN_W=10, DIGITS=3):
- bin_in=437, start pulse on edge 0:
  - done=1 exactly after edge 11, bcd_out=12'h437, ovf=0.
  - busy=1 on edges 1-10.
  - bcd_out unchanged before done.
- bin_in=0, then 999, then 1023, back-to-back starts in each DONE cycle:
  - 12'h000 ovf=0.
  - 12'h999 ovf=0.
  - 12'h999 ovf=1.
  - Three done pulses, 11 cycles apart.
- start pulsed at cycle 4 of a conversion of 250 with bin_in=777: result 12'h250, and a single done only.
- rst_n low at cycle 5 of a conversion of 512:
  - busy, done, ovf and bcd_out are 0 immediately (asynchronous).
  - No done after release.
  - A new start then converts correctly.
- SCORE_BCD_LZB_EN defined:
  - 7 -> 12'hFF7
  - 40 -> 12'hF40
  - 0 -> 12'hFF0
  - 305 -> 12'h305 (internal zero kept)
  - Undefined build: 7 -> 12'h007.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score binary-to-BCD converter.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble cell: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib,
  output logic [DIGIT_W-1:0] adj
);

  assign adj = (nib >= DIGIT_W'(5)) ? nib + DIGIT_W'(3) : nib;

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter for the score display, one bit per clock.
// Optional leading-zero blanking when SCORE_BCD_LZB_EN is defined.
module score_bcd_conv
  import score_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int          ACC_W   = DIGIT_W * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam longint      MAX_VAL = 10**DIGITS - 1;

  state_t                   state;
  logic [BIN_W-1:0]         bin_sr;
  logic [BIN_W-1:0]         bin_lat;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_adj;
  logic [CNT_W-1:0]         bit_cnt;
  logic [ACC_W+BIN_W-1:0]   shifted;
  logic                     sat;
  logic [ACC_W-1:0]         result;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (acc[g*DIGIT_W +: DIGIT_W]),
      .adj (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted = {acc_adj, bin_sr} << 1;

  // Saturation looks at the copy taken at start; bin_sr is consumed by the shift.
  assign sat = (64'(bin_lat) > 64'(MAX_VAL));

  // NOTE: every variable assigned in always_comb gets a value on every path first, otherwise a latch is inferred.
  always_comb begin
    result = sat ? {DIGITS{4'h9}} : acc;
`ifdef SCORE_BCD_LZB_EN
    begin : blank
      logic leading;
      leading = !sat;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (leading && (acc[i*DIGIT_W +: DIGIT_W] == '0)) begin
          result[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
      bin_sr  <= '0;
      bin_lat <= '0;
      acc     <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            bin_lat <= bin_in;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= shifted[ACC_W+BIN_W-1 -: ACC_W];
          bin_sr  <= shifted[BIN_W-1:0];
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          ovf     <= sat;
          bcd_out <= result;
          // A start here is accepted back-to-back without passing through IDLE.
          if (start) begin
            bin_sr  <= bin_in;
            bin_lat <= bin_in;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_conv.sv
// Self-checking bench for score_bcd_conv (BIN_W=10, DIGITS=3) against a decimal reference model.
module tb_score_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [11:0] bcd_out;

  int checks = 0;
  int errors = 0;

  score_bcd_conv #(.BIN_W(10), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal digits by plain arithmetic, with saturation and optional blanking.
  function automatic logic [11:0] model_bcd(input int v);
    int h, t, o;
    if (v > 999) return 12'h999;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
`ifdef SCORE_BCD_LZB_EN
    if (h == 0) begin
      h = 15;
      if (t == 0) t = 15;
    end
`endif
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges 1..10 after the start edge: busy high, no done, output frozen.
  task automatic wait_shift(input string tag);
    logic [11:0] prev;
    prev = bcd_out;
    for (int e = 1; e <= 10; e++) begin
      step();
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      check({tag, "_hold"}, bcd_out, prev);
    end
  endtask

  task automatic check_done(input string tag, input int v, input logic exp_busy);
    step();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, exp_busy);
    check({tag, "_bcd"}, bcd_out, model_bcd(v));
    check({tag, "_ovf"}, ovf, (v > 999));
  endtask

  task automatic conv(input string tag, input int v);
    bin_in = 10'(v);
    start  = 1'b1;
    step();
    start  = 1'b0;
    bin_in = 10'($urandom_range(0, 1023));
    wait_shift(tag);
    check_done(tag, v, 1'b0);
    step();
    check({tag, "_single"}, done, 1'b0);
  endtask

  initial begin
    int vals[3];
    int v;
    logic saw_done;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_bcd", bcd_out, 12'h000);
    rst_n = 1'b1;
    step();

    conv("c437", 437);
    check("c437_lit", bcd_out, 12'h437);

    // Back-to-back starts issued in each DONE-state cycle.
    vals = '{0, 999, 1023};
    bin_in = 10'(vals[0]);
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_shift("b2b");
      if (i < 2) begin
        bin_in = 10'(vals[i+1]);
        start  = 1'b1;
      end
      check_done("b2b", vals[i], (i < 2));
      start = 1'b0;
    end
    check("b2b_999_ovf", ovf, 1'b1);
    check("b2b_sat_lit", bcd_out, 12'h999);
    step();
    check("b2b_idle", busy, 1'b0);

    // A start during SHIFT is ignored.
    bin_in = 10'd250;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) begin
        bin_in = 10'd777;
        start  = 1'b1;
      end
      step();
      start = 1'b0;
      check("ign_nodone", done, 1'b0);
    end
    check_done("ign", 250, 1'b0);
    saw_done = 1'b0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("ign_single_done", saw_done, 1'b0);
    check("ign_no_restart", busy, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    bin_in = 10'd512;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    check("arst_bcd", bcd_out, 12'h000);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", saw_done, 1'b0);
    conv("post_rst", 512);

    // Leading-zero cases: model covers both builds, literal pins the 7 case.
    conv("z7", 7);
`ifdef SCORE_BCD_LZB_EN
    check("z7_lit", bcd_out, 12'hFF7);
`else
    check("z7_lit", bcd_out, 12'h007);
`endif
    conv("z40", 40);
    conv("z0", 0);
    conv("z305", 305);
    check("z305_lit", bcd_out, 12'h305);

    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 1023));
      conv("rnd", v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
